data_mem_mmio: RTL
==================

Name: data_mem_mmio

Overview:
Data-memory stage directly downstream of the single-cycle datapath. It consumes the ALU result as the address, the register-file read-data-2 as store data, and MemWrite from the control unit. It returns load data combinationally in the same cycle. It contains a word-addressed RAM plus a small memory-mapped I/O page: GPIO, a free-running cycle counter, and a compare timer with a sticky interrupt flag.

Parameters:
MEM_DEPTH, 64, number of 32-bit RAM words; must be a power of 2 and ≤16384.
GPIO_WIDTH, 8, width of the gpio_in and gpio_out ports (1..32).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
MemWrite  input  1  store strobe for the current instruction.
ALU_Out  input  32  byte address.
WriteData  input  32  store data.
RD  output  32  load data, combinational.
gpio_in  input  GPIO_WIDTH  external inputs; asynchronous to clk.
gpio_out  output  GPIO_WIDTH  registered GPIO output.
timer_irq  output  1  equals STATUS bit0.
bus_err  output  1  combinational; 1 when the address is unmapped and MemWrite=1.

Behaviour:
Address decode (ALU_Out[1:0] ignored; all accesses are full words):
- RAM: ALU_Out[31:16]==16'h0000 and word index ALU_Out[15:2] < MEM_DEPTH. Index = ALU_Out[log2(MEM_DEPTH)+1:2].
- IO: ALU_Out[31:16]==16'hFFFF. The register is selected by ALU_Out[7:0]:
  - 0x00 GPIO_OUT: R/W. Bits [GPIO_WIDTH-1:0] are stored; upper bits read 0.
  - 0x04 GPIO_IN: read-only. Returns the value after a 2-flop synchronizer (2-cycle input latency), zero-extended.
  - 0x08 CYCLE: R/W counter.
  - 0x0C COMPARE: R/W.
  - 0x10 STATUS: bit0 = match flag; other bits read 0.
  - All other offsets read 0; writes to them are ignored. bus_err is not asserted for these offsets.
- Anything else is unmapped: reads return 0, writes are ignored, and bus_err=1 while MemWrite=1.

Reads:
- RD is purely combinational from the current state, with no clock latency.
- Read-during-write to the same location returns the old value. The new value is visible the cycle after the write edge.

Writes:
- A write takes effect on the rising edge when MemWrite=1.
- When MemWrite=0, no state changes except CYCLE, the synchronizer and STATUS.

CYCLE:
- Increments by 1 every edge.
- Wraps 32'hFFFF_FFFF -> 0.
- A write to CYCLE loads WriteData on that edge. The load wins over the increment, so the next read is WriteData and the read after that is WriteData+1.

STATUS bit0:
- Set on an edge where COMPARE != 0 and CYCLE (pre-increment value) == COMPARE.
- Cleared by writing STATUS with WriteData[0]=1.
- If set and clear occur on the same edge, set wins.
- COMPARE==0 disables matching.

Reset (rst=0, immediate, independent of clk):
- All RAM words = 0.
- GPIO_OUT = 0, so gpio_out = 0.
- Synchronizer flops = 0.
- CYCLE = 0, COMPARE = 0, STATUS = 0, so timer_irq = 0.
- RD reflects the post-reset state; for example, RAM reads return 0.
- A reset asserted mid-store aborts the store.
- On release, CYCLE first increments at the first rising edge with rst=1.

Test Plan:
1. Reset, then store 0xDEADBEEF at address 0x0000_0008 and read it back. RD=0 during the store cycle; RD=0xDEADBEEF on the next cycle. Address 0x0000_000B also returns 0xDEADBEEF.
2. Store to 0x0000_0100 with MEM_DEPTH=64. The write is ignored, bus_err=1 during the store, and a subsequent read returns 0. A read of 0x1234_0000 returns 0 with bus_err=0.
3. Store 0xA5 to 0xFFFF_0000, so gpio_out=8'hA5 after the edge. Drive gpio_in=8'h3C, then read 0xFFFF_0004: 0x0000003C appears exactly 2 edges later.
4. Store 0xFFFF_FFFE to CYCLE. Consecutive reads return 0xFFFF_FFFE, 0xFFFF_FFFF, then 0x0000_0000 (wrap).
5. Set COMPARE=20 with CYCLE at 10. timer_irq rises after the edge where CYCLE==20 and stays high. Writing 1 to STATUS clears it. Repeat with a clear on the exact match edge: timer_irq remains 1.
6. Assert rst asynchronously mid-cycle while MemWrite=1 to RAM. All outputs go to their reset values immediately, and the RAM word remains 0 after release.

Source files
------------

// File: rtl/data_mem_mmio_if.sv
// Load/store bus between the datapath and the data-memory stage.
// RD and bus_err are combinational responses to the current request.
interface data_mem_mmio_if;
  logic        MemWrite;
  logic [31:0] ALU_Out;
  logic [31:0] WriteData;
  logic [31:0] RD;
  logic        bus_err;

  modport master (
    output MemWrite,
    output ALU_Out,
    output WriteData,
    input  RD,
    input  bus_err
  );

  modport slave (
    input  MemWrite,
    input  ALU_Out,
    input  WriteData,
    output RD,
    output bus_err
  );
endinterface

// File: rtl/data_mem_mmio.sv
// Word-addressed data RAM plus an MMIO page at 0xFFFF_xxxx: GPIO,
// a free-running cycle counter and a compare timer with a sticky match flag.
module data_mem_mmio #(
  parameter int unsigned MEM_DEPTH  = 64,
  parameter int unsigned GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_mmio_if.slave        bus,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  timer_irq
);

  localparam int unsigned AddrW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [5:0] SelGpioOut = 6'h00;
  localparam logic [5:0] SelGpioIn  = 6'h01;
  localparam logic [5:0] SelCycle   = 6'h02;
  localparam logic [5:0] SelCompare = 6'h03;
  localparam logic [5:0] SelStatus  = 6'h04;

  logic [31:0]           mem_q [MEM_DEPTH];
  logic [GPIO_WIDTH-1:0] gpio_q, sync1_q, sync2_q;
  logic [31:0]           cycle_q, cycle_d;
  logic [31:0]           compare_q;
  logic                  status_q, status_d;

  logic             ram_hit, io_hit;
  logic [AddrW-1:0] ram_idx;
  logic [5:0]       io_sel;
  logic             io_we;

  // Byte offset within a word is ignored; all accesses are full words.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.ALU_Out[1:0];

  assign ram_hit = (bus.ALU_Out[31:16] == 16'h0000) &&
                   ({18'd0, bus.ALU_Out[15:2]} < MEM_DEPTH);
  assign ram_idx = bus.ALU_Out[AddrW+1:2];
  assign io_hit  = (bus.ALU_Out[31:16] == 16'hFFFF);
  assign io_sel  = bus.ALU_Out[7:2];
  assign io_we   = bus.MemWrite && io_hit;

  assign bus.bus_err = bus.MemWrite && !ram_hit && !io_hit;

  always_comb begin
    bus.RD = '0;
    if (ram_hit) begin
      bus.RD = mem_q[ram_idx];
    end else if (io_hit) begin
      case (io_sel)
        SelGpioOut: bus.RD[GPIO_WIDTH-1:0] = gpio_q;
        SelGpioIn:  bus.RD[GPIO_WIDTH-1:0] = sync2_q;
        SelCycle:   bus.RD = cycle_q;
        SelCompare: bus.RD = compare_q;
        SelStatus:  bus.RD[0] = status_q;
        default:    bus.RD = '0;
      endcase
    end
  end

  // A CYCLE store overrides the increment on the same edge.
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (io_we && io_sel == SelCycle) cycle_d = bus.WriteData;
  end

  // Match is checked against the pre-increment count; set beats clear.
  always_comb begin
    status_d = status_q;
    if (io_we && io_sel == SelStatus && bus.WriteData[0]) status_d = 1'b0;
    if (compare_q != 32'd0 && cycle_q == compare_q) status_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem_q[i] <= '0;
    end else if (bus.MemWrite && ram_hit) begin
      mem_q[ram_idx] <= bus.WriteData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      cycle_q   <= '0;
      compare_q <= '0;
      status_q  <= 1'b0;
    end else begin
      sync1_q  <= gpio_in;
      sync2_q  <= sync1_q;
      cycle_q  <= cycle_d;
      status_q <= status_d;
      if (io_we && io_sel == SelGpioOut) gpio_q <= bus.WriteData[GPIO_WIDTH-1:0];
      if (io_we && io_sel == SelCompare) compare_q <= bus.WriteData;
    end
  end

  assign gpio_out  = gpio_q;
  assign timer_irq = status_q;

endmodule
